messbauer_sync_decoder: RTL
===========================

Name: messbauer_sync_decoder

Overview:
- Receive-side counterpart of the Mossbauer start/channel generator.
- Samples the asynchronous start (active-low frame marker) and channel (boundary toggle) lines, recovers the channel index, and counts detector events per channel.
- Emits one {channel, count} record per channel over a valid/ready interface to the spectrum accumulator.
- Flags malformed frames, short starts, record overruns and, optionally, stalled channel timing.

Parameters:
- CHANNEL_NUMBER, 512, channels per frame; power of 2, at most 4096.
- START_MIN_DURATION, 40, minimum start low width in aclk cycles for a start to be accepted.
- CHANNEL_TYPE, 2, 1 = start-and-channel-sync mode, 2 = channel-after-measure mode.
- COUNT_WIDTH, 16, width of the per-channel event counter.
- CHANNEL_TIMEOUT, 6400, maximum aclk cycles between channel boundaries; used only with the optional feature.

Ports:
- aclk  in  1  system clock, 50 MHz.
- areset  in  1  asynchronous active-high reset.
- start  in  1  asynchronous frame start line; active low.
- channel  in  1  asynchronous channel boundary line.
- event_in  in  1  asynchronous detector event pulse; rising edge = one event.
- rec_ready  in  1  downstream accepts the current record.
- err_clear  in  1  single-cycle pulse; clears all sticky error flags.
- rec_valid  out  1  record available.
- rec_channel  out  12  channel index of the record.
- rec_count  out  COUNT_WIDTH  events counted in that channel.
- frame_active  out  1  high while in ACQUIRE.
- frame_done  out  1  one-cycle pulse when a complete frame ends.
- channel_index  out  12  current channel being counted.
- frame_count  out  16  number of completed frames; wraps at 65535 to 0.
- start_err, frame_err, overrun_err, timeout_err  out  1 each  sticky error flags.

Behaviour:
- **Reset:** areset is asynchronous and takes effect immediately, mid-operation included. State = IDLE. All outputs are 0. Synchronizer stages reset to start=1, channel=1, event_in=0.
- **Input sampling:** start, channel and event_in each pass through a 2-FF synchronizer plus an edge register. An input pin edge is acted on exactly 3 aclk cycles later.
- **Boundary edge:** CHANNEL_TYPE=2 uses the channel rising edge. CHANNEL_TYPE=1 uses the channel falling edge; the first boundary after start is discarded (no record), so there are CHANNEL_NUMBER+1 boundaries per frame.
- **FSM IDLE:** on start falling edge, go to START_LOW and clear low_cnt.
- **FSM START_LOW:**
  - low_cnt increments each cycle, saturating.
  - On start rising edge with low_cnt >= START_MIN_DURATION: go to ACQUIRE, set channel_index=0, event count=0, frame_active=1.
  - On start rising edge with low_cnt < START_MIN_DURATION: set start_err and go to IDLE.
- **FSM ACQUIRE:**
  - Each event rising edge increments the count, saturating at 2^COUNT_WIDTH-1.
  - Each boundary edge produces a record {channel_index, count}, then channel_index increments and the count clears.
  - On the boundary for channel CHANNEL_NUMBER-1: the last record is emitted, frame_done pulses, frame_count increments, frame_active drops, and the FSM goes to IDLE.
- **Simultaneous events:**
  - An event edge and a boundary edge in the same cycle: the event counts into the closing channel.
  - A start falling edge in ACQUIRE before the final boundary: set frame_err, discard the partial channel (no record), drop frame_active, go to START_LOW with low_cnt=0.
  - A start falling edge and a boundary in the same cycle: the start wins; no record.
- **Record handshake:**
  - rec_valid and the record fields are registered and appear 1 cycle after the boundary decision.
  - rec_valid holds until a cycle with rec_valid && rec_ready.
  - A new record arriving while rec_valid=1 and rec_ready=0 is dropped; overrun_err is set and the existing record is kept.
  - If rec_ready=1 in the same cycle, the new record is loaded and rec_valid stays 1.
- **Errors:** all error flags are sticky until err_clear. If err_clear and a new error occur in the same cycle, the flag ends up set.

Optional Feature:
- Macro MESSBAUER_DECODER_TIMEOUT_EN.
- Defined:
  - A watchdog counts aclk cycles in ACQUIRE and clears on every boundary.
  - Reaching CHANNEL_TIMEOUT sets timeout_err, drops frame_active, returns to IDLE and emits no record.
- Undefined: no watchdog logic; timeout_err is tied to 0.

Test Plan (bench params CHANNEL_NUMBER=4, START_MIN_DURATION=10, CHANNEL_TYPE=2, COUNT_WIDTH=4, CHANNEL_TIMEOUT=200):
- Start low 20 cycles, 4 channel rising edges 100 cycles apart with 0/1/2/3 events, rec_ready=1 -> records (0,0),(1,1),(2,2),(3,3); frame_done one pulse; frame_count=1; no error flags.
- Start low 5 cycles -> start_err=1, FSM stays IDLE, no records; err_clear pulse -> start_err=0.
- Valid start, 2 channels, then start low 20 cycles -> frame_err=1, only records 0 and 1; new frame decodes from channel 0.
- rec_ready=0 across 2 boundaries -> first record held, second dropped, overrun_err=1.
- 20 events in one channel -> rec_count=15 (saturated); event edge in the same cycle as a boundary -> counted in the closing channel.
- With macro defined, no boundary for 250 cycles in ACQUIRE -> timeout_err=1, frame_active=0; without the macro -> timeout_err stays 0. Assert areset mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/messbauer_sync_decoder.sv
// messbauer_sync_decoder
//   Receive side of the Mossbauer start/channel link. The asynchronous start
//   and channel lines and the detector event line are synchronized. The
//   channel index is recovered from the channel boundaries, and detector
//   events are counted per channel. One {channel, count} record per channel
//   is sent downstream over a valid/ready handshake.
//
//   Optional build macro: MESSBAUER_DECODER_TIMEOUT_EN
//     Defined   : a watchdog aborts a frame when channel boundaries stall.
//     Undefined : there is no watchdog, and timeout_err is tied low.
//
// Ports
//   aclk, areset          clock; asynchronous active-high reset
//   start                 frame marker, active low (asynchronous)
//   channel               channel boundary line (asynchronous)
//   event_in              detector pulse; each rising edge is one event
//   rec_ready             downstream accepts the current record
//   err_clear             pulse that clears the sticky error flags
//   rec_valid/rec_channel/rec_count   record output
//   frame_active          high while acquiring a frame
//   frame_done            one-cycle pulse at the end of a complete frame
//   channel_index         channel currently being counted
//   frame_count           number of completed frames (wraps)
//   start_err, frame_err, overrun_err, timeout_err   sticky error flags
module messbauer_sync_decoder #(
  parameter int CHANNEL_NUMBER     = 512,
  parameter int START_MIN_DURATION = 40,
  parameter int CHANNEL_TYPE       = 2,
  parameter int COUNT_WIDTH        = 16,
  parameter int CHANNEL_TIMEOUT    = 6400
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   channel,
  input  logic                   event_in,
  input  logic                   rec_ready,
  input  logic                   err_clear,
  output logic                   rec_valid,
  output logic [11:0]            rec_channel,
  output logic [COUNT_WIDTH-1:0] rec_count,
  output logic                   frame_active,
  output logic                   frame_done,
  output logic [11:0]            channel_index,
  output logic [15:0]            frame_count,
  output logic                   start_err,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   timeout_err
);

  localparam int                   LOW_W   = $clog2(START_MIN_DURATION + 2);
  localparam logic [LOW_W-1:0]     LOW_SAT = LOW_W'(START_MIN_DURATION);
  localparam logic [11:0]          LAST_CH = 12'(CHANNEL_NUMBER - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_LOW = 2'd1,
    ACQUIRE   = 2'd2
  } state_t;

  state_t state_r, next_state_s;

  logic start_meta_r, start_sync_r, start_prev_r;
  logic chan_meta_r,  chan_sync_r,  chan_prev_r;
  logic ev_meta_r,    ev_sync_r,    ev_prev_r;

  logic start_fall_s, start_rise_s, chan_rise_s, chan_fall_s, ev_rise_s, bound_edge_s;

  logic [LOW_W-1:0]       low_cnt_r, low_cnt_nx_s;
  logic [11:0]            chan_idx_r, chan_nx_s;
  logic [COUNT_WIDTH-1:0] cnt_r, cnt_nx_s, cnt_inc_s, rec_cnt_s;
  logic                   skip_r, skip_nx_s;
  logic                   rec_load_s, done_s, start_err_set_s, frame_err_set_s, overrun_set_s;
  logic                   wd_hit_s;

  logic                   rec_valid_r, frame_active_r, frame_done_r;
  logic [11:0]            rec_channel_r;
  logic [COUNT_WIDTH-1:0] rec_count_r;
  logic [15:0]            frame_count_r;
  logic                   start_err_r, frame_err_r, overrun_err_r;

  // Two-FF synchronizers plus one edge register per asynchronous input.
  // start and channel idle high, and event_in idles low.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      start_meta_r <= 1'b1; start_sync_r <= 1'b1; start_prev_r <= 1'b1;
      chan_meta_r  <= 1'b1; chan_sync_r  <= 1'b1; chan_prev_r  <= 1'b1;
      ev_meta_r    <= 1'b0; ev_sync_r    <= 1'b0; ev_prev_r    <= 1'b0;
    end else begin
      start_meta_r <= start;    start_sync_r <= start_meta_r; start_prev_r <= start_sync_r;
      chan_meta_r  <= channel;  chan_sync_r  <= chan_meta_r;  chan_prev_r  <= chan_sync_r;
      ev_meta_r    <= event_in; ev_sync_r    <= ev_meta_r;    ev_prev_r    <= ev_sync_r;
    end
  end

  assign start_fall_s = start_prev_r & ~start_sync_r;
  assign start_rise_s = ~start_prev_r & start_sync_r;
  assign chan_rise_s  = ~chan_prev_r & chan_sync_r;
  assign chan_fall_s  = chan_prev_r & ~chan_sync_r;
  assign ev_rise_s    = ~ev_prev_r & ev_sync_r;
  assign bound_edge_s = (CHANNEL_TYPE == 1) ? chan_fall_s : chan_rise_s;

  // An event that lands on the boundary cycle is folded into this value, so
  // it counts in the channel that is closing.
  assign cnt_inc_s = (ev_rise_s && (cnt_r != CNT_MAX)) ? (cnt_r + CNT_ONE) : cnt_r;

`ifdef MESSBAUER_DECODER_TIMEOUT_EN
  localparam int               WD_W     = $clog2(CHANNEL_TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(CHANNEL_TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};
  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_err_r, to_set_s;

  assign wd_hit_s = (state_r == ACQUIRE) && (wd_cnt_r >= WD_LIMIT);
  // The abort fires only when no start edge and no boundary pre-empts it in
  // that cycle. This mirrors the priority used by the FSM.
  assign to_set_s = wd_hit_s && !start_fall_s && !bound_edge_s;

  // Watchdog: counts cycles spent in ACQUIRE and restarts on every boundary.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wd_cnt_r      <= {WD_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if ((state_r == ACQUIRE) && (next_state_s == ACQUIRE) && !bound_edge_s) begin
        wd_cnt_r <= wd_cnt_r + WD_ONE;
      end else begin
        wd_cnt_r <= {WD_W{1'b0}};
      end
      timeout_err_r <= to_set_s | (timeout_err_r & ~err_clear);
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign wd_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus the next values for the frame datapath.
  always_comb begin
    next_state_s    = state_r;
    low_cnt_nx_s    = low_cnt_r;
    chan_nx_s       = chan_idx_r;
    cnt_nx_s        = cnt_r;
    skip_nx_s       = skip_r;
    rec_load_s      = 1'b0;
    rec_cnt_s       = cnt_inc_s;
    done_s          = 1'b0;
    start_err_set_s = 1'b0;
    frame_err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_fall_s) begin
          next_state_s = START_LOW;
          low_cnt_nx_s = {LOW_W{1'b0}};
        end else begin
          next_state_s = IDLE;
        end
      end
      START_LOW: begin
        if (start_rise_s) begin
          if (low_cnt_r >= LOW_SAT) begin
            next_state_s = ACQUIRE;
            chan_nx_s    = 12'd0;
            cnt_nx_s     = {COUNT_WIDTH{1'b0}};
            // In sync mode the first boundary only opens channel 0.
            skip_nx_s    = (CHANNEL_TYPE == 1);
          end else begin
            start_err_set_s = 1'b1;
            next_state_s    = IDLE;
          end
        end else if (low_cnt_r != LOW_SAT) begin
          low_cnt_nx_s = low_cnt_r + {{(LOW_W-1){1'b0}}, 1'b1};
        end else begin
          low_cnt_nx_s = low_cnt_r;
        end
      end
      ACQUIRE: begin
        if (start_fall_s) begin
          // A new start during a frame aborts the frame, and the partial
          // channel is discarded.
          frame_err_set_s = 1'b1;
          next_state_s    = START_LOW;
          low_cnt_nx_s    = {LOW_W{1'b0}};
          chan_nx_s       = 12'd0;
          cnt_nx_s        = {COUNT_WIDTH{1'b0}};
        end else if (bound_edge_s) begin
          cnt_nx_s = {COUNT_WIDTH{1'b0}};
          if (skip_r) begin
            skip_nx_s = 1'b0;
          end else if (chan_idx_r == LAST_CH) begin
            rec_load_s   = 1'b1;
            done_s       = 1'b1;
            chan_nx_s    = 12'd0;
            next_state_s = IDLE;
          end else begin
            rec_load_s = 1'b1;
            chan_nx_s  = chan_idx_r + 12'd1;
          end
        end else if (wd_hit_s) begin
          next_state_s = IDLE;
          chan_nx_s    = 12'd0;
          cnt_nx_s     = {COUNT_WIDTH{1'b0}};
        end else begin
          cnt_nx_s = cnt_inc_s;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign overrun_set_s = rec_load_s & rec_valid_r & ~rec_ready;

  // Frame datapath, status outputs and sticky error flags. A flag that is
  // set in the same cycle as err_clear stays set.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      low_cnt_r      <= {LOW_W{1'b0}};
      chan_idx_r     <= 12'd0;
      cnt_r          <= {COUNT_WIDTH{1'b0}};
      skip_r         <= 1'b0;
      frame_active_r <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_count_r  <= 16'd0;
      start_err_r    <= 1'b0;
      frame_err_r    <= 1'b0;
      overrun_err_r  <= 1'b0;
    end else begin
      low_cnt_r      <= low_cnt_nx_s;
      chan_idx_r     <= chan_nx_s;
      cnt_r          <= cnt_nx_s;
      skip_r         <= skip_nx_s;
      frame_active_r <= (next_state_s == ACQUIRE);
      frame_done_r   <= done_s;
      frame_count_r  <= done_s ? (frame_count_r + 16'd1) : frame_count_r;
      start_err_r    <= start_err_set_s | (start_err_r & ~err_clear);
      frame_err_r    <= frame_err_set_s | (frame_err_r & ~err_clear);
      overrun_err_r  <= overrun_set_s | (overrun_err_r & ~err_clear);
    end
  end

  // Record register. A held, unaccepted record is never overwritten.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rec_valid_r   <= 1'b0;
      rec_channel_r <= 12'd0;
      rec_count_r   <= {COUNT_WIDTH{1'b0}};
    end else if (rec_load_s && (!rec_valid_r || rec_ready)) begin
      rec_valid_r   <= 1'b1;
      rec_channel_r <= chan_idx_r;
      rec_count_r   <= rec_cnt_s;
    end else if (rec_valid_r && rec_ready) begin
      rec_valid_r   <= 1'b0;
    end else begin
      rec_valid_r   <= rec_valid_r;
    end
  end

  assign rec_valid     = rec_valid_r;
  assign rec_channel   = rec_channel_r;
  assign rec_count     = rec_count_r;
  assign frame_active  = frame_active_r;
  assign frame_done    = frame_done_r;
  assign channel_index = chan_idx_r;
  assign frame_count   = frame_count_r;
  assign start_err     = start_err_r;
  assign frame_err     = frame_err_r;
  assign overrun_err   = overrun_err_r;

endmodule
